// File: rtl/stream_token_pkg.sv
// Shared token definitions for the sparse-stream sink and its companion sources.
package stream_token_pkg;

  localparam int unsigned         TOKEN_W    = 17;
  localparam logic [TOKEN_W-1:0]  DONE_TOKEN = 17'h10100;
  // Feedback taps 16,14,13,11 expressed as a mask over state bits [15:0].
  localparam logic [15:0]         LFSR_TAPS  = 16'hB400;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } sink_state_t;

  function automatic logic is_done(input logic [TOKEN_W-1:0] tok);
    return tok == DONE_TOKEN;
  endfunction

  function automatic logic is_stop(input logic [TOKEN_W-1:0] tok);
    return tok[16] && (tok[9:8] == 2'b00);
  endfunction

  function automatic logic is_data(input logic [TOKEN_W-1:0] tok);
    return !tok[16];
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous seed load and advance enable.
module lfsr16
  import stream_token_pkg::*;
(
  input  logic        clk,
  input  logic        load,
  input  logic        enable,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  logic feedback;

  always_comb begin
    feedback = ^(state & LFSR_TAPS);
  end

  always_ff @(posedge clk) begin
    if (load) begin
      state <= seed;
    end else if (enable) begin
      state <= {state[14:0], feedback};
    end
  end

endmodule

// File: rtl/stream_token_sink.sv
// Ready/valid token sink: checks an incoming sparse token stream against a
// preloaded expected sequence under optional pseudo-random backpressure.
module stream_token_sink
  import stream_token_pkg::*;
#(
  parameter int unsigned DATA_W    = 17,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned AW        = $clog2(DEPTH),
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              exp_wr_en,
  input  logic [AW-1:0]     exp_wr_addr,
  input  logic [DATA_W-1:0] exp_wr_data,
  input  logic [AW:0]       exp_count,
  input  logic              stall_en,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              done,
  output logic              pass,
  output logic [AW:0]       token_count,
  output logic [15:0]       mismatch_count,
  output logic [15:0]       stop_count,
  output logic [AW:0]       first_err_idx,
  output logic              overrun,
  output logic [31:0]       run_cycles
);

  sink_state_t       state, next_state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] exp_tok;
  logic [15:0]       lfsr;
  logic              accept, over_idx, mism, start_run, next_ready;

  lfsr16 u_lfsr (
    .clk    (clk),
    .load   (rst || flush),
    .enable (state == S_RUN),
    .seed   (LFSR_SEED),
    .state  (lfsr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (exp_wr_en && state == S_IDLE) begin
      mem[exp_wr_addr] <= exp_wr_data;
    end
  end

  always_comb begin
    exp_tok   = mem[token_count[AW-1:0]];
    accept    = valid && ready && (state == S_RUN);
    over_idx  = token_count >= exp_count;
    mism      = over_idx || (data != exp_tok);
    start_run = start && (state != S_RUN);

    next_state = state;
    unique case (state)
      S_IDLE:  if (start) next_state = S_RUN;
      S_RUN:   if (accept && is_done(data)) next_state = S_DONE;
      S_DONE:  if (start) next_state = S_RUN;
      default: next_state = S_IDLE;
    endcase

    next_ready = (next_state == S_RUN) && (!stall_en || lfsr[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state          <= S_IDLE;
      ready          <= 1'b0;
      done           <= 1'b0;
      token_count    <= '0;
      mismatch_count <= '0;
      stop_count     <= '0;
      first_err_idx  <= '1;
      overrun        <= 1'b0;
      run_cycles     <= '0;
    end else begin
      state <= next_state;
      ready <= next_ready;
      if (start_run) begin
        done           <= 1'b0;
        token_count    <= '0;
        mismatch_count <= '0;
        stop_count     <= '0;
        first_err_idx  <= '1;
        overrun        <= 1'b0;
        run_cycles     <= '0;
      end else if (state == S_RUN) begin
        if (run_cycles != '1) run_cycles <= run_cycles + 32'd1;
        if (accept) begin
          if (token_count != '1) token_count <= token_count + 1'b1;
          if (is_stop(data) && stop_count != '1) stop_count <= stop_count + 16'd1;
          if (over_idx) overrun <= 1'b1;
          if (mism) begin
            if (mismatch_count == '0) first_err_idx <= token_count;
            if (mismatch_count != '1) mismatch_count <= mismatch_count + 16'd1;
          end
          if (is_done(data)) done <= 1'b1;
        end
      end
    end
  end

  // Evaluated from the settled counters so a late exp_count change is reflected.
  always_comb begin
    pass = done && (mismatch_count == '0) && !overrun && (token_count == exp_count);
  end

endmodule

// File: tb/tb_stream_token_sink.sv
// Randomized self-checking bench for stream_token_sink with a queue-based reference model.
module tb_stream_token_sink;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;
  localparam logic [16:0] DONE_T = 17'h10100;

  logic          clk = 1'b0;
  logic          rst, flush, exp_wr_en, stall_en, start, valid;
  logic [AW-1:0] exp_wr_addr;
  logic [16:0]   exp_wr_data, data;
  logic [AW:0]   exp_count;
  logic          ready, done, pass, overrun;
  logic [AW:0]   token_count, first_err_idx;
  logic [15:0]   mismatch_count, stop_count;
  logic [31:0]   run_cycles;

  logic [16:0] mem_m [DEPTH];
  logic [16:0] send_q[$];
  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  stream_token_sink #(.DATA_W(17), .DEPTH(DEPTH), .AW(AW), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .exp_wr_en(exp_wr_en), .exp_wr_addr(exp_wr_addr),
    .exp_wr_data(exp_wr_data), .exp_count(exp_count), .stall_en(stall_en), .start(start),
    .data(data), .valid(valid), .ready(ready), .done(done), .pass(pass),
    .token_count(token_count), .mismatch_count(mismatch_count), .stop_count(stop_count),
    .first_err_idx(first_err_idx), .overrun(overrun), .run_cycles(run_cycles)
  );

  task automatic write_exp(input int unsigned a, input logic [16:0] t, input bit taken);
    @(negedge clk);
    exp_wr_en = 1'b1; exp_wr_addr = a[AW-1:0]; exp_wr_data = t;
    @(negedge clk);
    exp_wr_en = 1'b0;
    if (taken) mem_m[a] = t;
  endtask

  task automatic preload_std();
    write_exp(0, 17'h00001, 1'b1);
    write_exp(1, 17'h00003, 1'b1);
    write_exp(2, 17'h10000, 1'b1);
    write_exp(3, DONE_T, 1'b1);
  endtask

  task automatic do_flush();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
  endtask

  task automatic start_run(input bit late, input int unsigned la, input logic [16:0] lt);
    @(negedge clk);
    start = 1'b1;
    if (late) begin exp_wr_en = 1'b1; exp_wr_addr = la[AW-1:0]; exp_wr_data = lt; end
    @(negedge clk);
    start = 1'b0; exp_wr_en = 1'b0;
    if (late) mem_m[la] = lt;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL start_done got=%0b want=0", done); end
    checks++; if (token_count !== '0) begin failures++; $display("FAIL start_tcount got=%0d want=0", token_count); end
    checks++; if (first_err_idx !== '1) begin failures++; $display("FAIL start_ferr got=%0h want=1ff", first_err_idx); end
  endtask

  task automatic drive(input int unsigned max_acc, output int unsigned n_acc, output int unsigned cycles);
    int unsigned k = 0;
    bit fin = 1'b0;
    bit r;
    cycles = 0;
    while (!fin) begin
      if (cycles >= 4000) begin
        checks++; failures++;
        $display("FAIL drive_timeout accepted=%0d want=%0d", k, send_q.size());
        break;
      end
      data = send_q[k]; valid = 1'b1; r = ready; cycles++;
      @(negedge clk);
      if (r) begin
        k++;
        if (send_q[k-1] == DONE_T || k == max_acc || k >= send_q.size()) fin = 1'b1;
      end
      checks++;
      if (token_count !== k[AW:0]) begin
        failures++; $display("FAIL accept_count got=%0d want=%0d", token_count, k);
      end
    end
    valid = 1'b0;
    n_acc = k;
  endtask

  task automatic check_outcome(input int unsigned cycles, input string tag);
    int unsigned n = 0, mis = 0, stops = 0, ferr = 'h1ff;
    bit ov = 1'b0, p;
    foreach (send_q[i]) begin
      bit oi = (i >= exp_count);
      n++;
      if (oi) ov = 1'b1;
      if (send_q[i][16] && send_q[i][9:8] == 2'b00) stops++;
      if (oi || send_q[i] !== mem_m[i]) begin
        if (mis == 0) ferr = i;
        mis++;
      end
      if (send_q[i] == DONE_T) break;
    end
    p = (mis == 0) && !ov && (n == exp_count);
    data = 17'($urandom); valid = 1'b1;
    repeat (3) @(negedge clk);
    valid = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL %s done got=%0b want=1", tag, done); end
    checks++; if (pass !== p) begin failures++; $display("FAIL %s pass got=%0b want=%0b", tag, pass, p); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL %s ready got=%0b want=0", tag, ready); end
    checks++; if (token_count !== n[AW:0]) begin failures++; $display("FAIL %s tcount got=%0d want=%0d", tag, token_count, n); end
    checks++; if (mismatch_count !== mis[15:0]) begin failures++; $display("FAIL %s mism got=%0d want=%0d", tag, mismatch_count, mis); end
    checks++; if (stop_count !== stops[15:0]) begin failures++; $display("FAIL %s stops got=%0d want=%0d", tag, stop_count, stops); end
    checks++; if (first_err_idx !== ferr[AW:0]) begin failures++; $display("FAIL %s ferr got=%0h want=%0h", tag, first_err_idx, ferr); end
    checks++; if (overrun !== ov) begin failures++; $display("FAIL %s overrun got=%0b want=%0b", tag, overrun, ov); end
    checks++; if (run_cycles !== cycles) begin failures++; $display("FAIL %s run_cycles got=%0d want=%0d", tag, run_cycles, cycles); end
  endtask

  task automatic run_seq(input bit stall, input string tag);
    int unsigned n, cyc;
    stall_en = stall;
    start_run(1'b0, 0, '0);
    drive(0, n, cyc);
    check_outcome(cyc, tag);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    foreach (mem_m[i]) mem_m[i] = '0;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%0b want=0", ready); end
    checks++; if (done !== 1'b0 || pass !== 1'b0 || overrun !== 1'b0) begin
      failures++; $display("FAIL rst_flags got=%0b%0b%0b want=000", done, pass, overrun); end
    checks++; if (token_count !== '0 || mismatch_count !== '0 || stop_count !== '0 || run_cycles !== '0) begin
      failures++; $display("FAIL rst_counts got=%0d/%0d/%0d/%0d want=0", token_count, mismatch_count, stop_count, run_cycles); end
    checks++; if (first_err_idx !== '1) begin failures++; $display("FAIL rst_ferr got=%0h want=1ff", first_err_idx); end
  endtask

  task automatic test_single_fiber();
    preload_std();
    exp_count = 9'd4;
    send_q = '{17'h00001, 17'h00003, 17'h10000, DONE_T};
    run_seq(1'b0, "single");
  endtask

  task automatic test_backpressure();
    send_q = '{17'h00001, 17'h00003, 17'h10000, DONE_T};
    run_seq(1'b1, "backpressure");
  endtask

  task automatic test_mismatch();
    send_q = '{17'h00001, 17'h00004, 17'h10000, DONE_T};
    run_seq(1'b1, "mismatch");
  endtask

  task automatic test_overrun_early_done();
    exp_count = 9'd2;
    send_q = '{17'h00001, 17'h00003, DONE_T};
    run_seq(1'b0, "overrun");
    exp_count = 9'd4;
    send_q = '{17'h00001, DONE_T};
    run_seq(1'b0, "early_done");
  endtask

  task automatic test_flush();
    int unsigned n, cyc;
    send_q = '{17'h00001, 17'h00003, 17'h10000, DONE_T};
    stall_en = 1'b0;
    start_run(1'b0, 0, '0);
    drive(2, n, cyc);
    data = send_q[2]; valid = 1'b1;
    do_flush();
    valid = 1'b0;
    checks++; if (token_count !== '0 || run_cycles !== '0) begin
      failures++; $display("FAIL flush_counts got=%0d/%0d want=0/0", token_count, run_cycles); end
    checks++; if (ready !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL flush_flags got=%0b%0b want=00", ready, done); end
    run_seq(1'b1, "after_flush");
  endtask

  task automatic test_restart();
    write_exp(0, 17'h1FFFF, 1'b0);
    send_q = '{17'h00005, 17'h00003, 17'h10000, DONE_T};
    run_seq(1'b0, "restart_bad");
    send_q = '{17'h00001, 17'h00003, 17'h10000, DONE_T};
    run_seq(1'b1, "restart_good");
  endtask

  task automatic test_random();
    logic [16:0] expq[$];
    for (int it = 0; it < 8; it++) begin
      int unsigned len = $urandom_range(3, 40);
      int unsigned ec;
      int unsigned n, cyc;
      expq = {};
      for (int unsigned j = 0; j + 1 < len; j++) begin
        if ($urandom_range(0, 3) == 0)
          expq.push_back({1'b1, 6'($urandom), 2'b00, 8'($urandom)});
        else
          expq.push_back({1'b0, 16'($urandom)});
      end
      expq.push_back(DONE_T);
      do_flush();
      for (int unsigned j = 0; j + 1 < len; j++) write_exp(j, expq[j], 1'b1);
      case ($urandom_range(0, 4))
        0:       ec = len - 1;
        1:       ec = len + 1;
        default: ec = len;
      endcase
      exp_count = ec[AW:0];
      send_q = {};
      foreach (expq[j]) begin
        logic [16:0] t = expq[j];
        if (t != DONE_T && $urandom_range(0, 5) == 0) t[$urandom_range(0, 7)] ^= 1'b1;
        send_q.push_back(t);
      end
      stall_en = 1'($urandom);
      start_run(1'b1, len - 1, DONE_T);
      drive(0, n, cyc);
      check_outcome(cyc, "random");
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; exp_wr_en = 1'b0; exp_wr_addr = '0; exp_wr_data = '0;
    exp_count = '0; stall_en = 1'b0; start = 1'b0; data = '0; valid = 1'b0;
    test_reset();
    test_single_fiber();
    test_backpressure();
    test_mismatch();
    test_overrun_early_done();
    test_flush();
    test_restart();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
